// File: rtl/aes_pkg.sv
// Shared AES definitions: word/key types, key-length modes, FSM states and
// per-mode round parameters used by the key-expansion datapath.
package aes_pkg;

    typedef logic [31:0]  aes_word;
    typedef logic [127:0] key_128;

    typedef enum logic [1:0] {
        KEY_LEN_128 = 2'd0,
        KEY_LEN_192 = 2'd1,
        KEY_LEN_256 = 2'd2,
        KEY_LEN_BAD = 2'd3
    } key_len_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DRAIN  = 2'd3
    } ke_state_e;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_word rot_word(input aes_word w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [3:0] nk_of(input key_len_e m);
        case (m)
            KEY_LEN_192: return NK_192;
            KEY_LEN_256: return NK_256;
            default:     return NK_128;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_len_e m);
        case (m)
            KEY_LEN_192: return NR_192;
            KEY_LEN_256: return NR_256;
            default:     return NR_128;
        endcase
    endfunction

    function automatic int key_bits_of(input key_len_e m);
        case (m)
            KEY_LEN_128: return 128;
            KEY_LEN_192: return 192;
            KEY_LEN_256: return 256;
            default:     return 0;
        endcase
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant sequencer: restarts at 8'h01 on load, advances by xtime on
// each step.
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       step_i,
    output logic [7:0] rcon_o
);

    logic [7:0] rcon_q;

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcon_q <= 8'h01;
        end else if (load_i) begin
            rcon_q <= 8'h01;
        end else if (step_i) begin
            rcon_q <= xtime(rcon_q);
        end
    end

    assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_key_expand.sv
// AES key expansion (128/192/256) producing one schedule word per cycle and
// presenting 128-bit round keys over a valid/ready handshake.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int KEY_BITS_MAX = 256,
    parameter int RK_IDX_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [1:0]              key_len_i,
    input  logic [KEY_BITS_MAX-1:0] key_i,
    input  logic                    flush_i,
    output logic [31:0]             sub_o,
    input  logic [31:0]             sub_i,
    output logic [127:0]            rk_o,
    output logic                    rk_valid_o,
    input  logic                    rk_ready_i,
    output logic [RK_IDX_W-1:0]     rk_idx_o,
    output logic                    rk_last_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    ke_state_e               state_q, state_d;
    key_len_e                mode_q;
    logic [KEY_BITS_MAX-1:0] key_q;
    aes_word                 win_q [8];
    aes_word                 col_q [4];
    logic [1:0]              col_cnt_q;
    logic [5:0]              word_cnt_q;
    logic [2:0]              phase_q;
    logic [RK_IDX_W-1:0]     rk_cnt_q;
    logic [RK_IDX_W-1:0]     rk_idx_q;
    logic [127:0]            rk_q;
    logic                    rk_valid_q;
    logic                    rk_last_q;
    logic                    err_q;

    logic [7:0]  rcon;
    logic        mode_ok;
    logic        accept;
    logic        hs;
    logic        stall;
    logic        producing;
    logic        use_rcon;
    logic        phase_wrap;
    logic [3:0]  nk_cur;
    logic [3:0]  nr_cur;
    logic [5:0]  nw_last;
    aes_word     w_old;
    aes_word     temp;
    aes_word     new_word;

    assign mode_ok = (key_len_e'(key_len_i) != KEY_LEN_BAD) &&
                     (key_bits_of(key_len_e'(key_len_i)) <= KEY_BITS_MAX);
    assign accept  = (state_q == ST_IDLE) && start_i && mode_ok && !flush_i;

    assign nk_cur     = nk_of(mode_q);
    assign nr_cur     = nr_of(mode_q);
    assign nw_last    = {nr_cur, 2'b11};
    assign phase_wrap = ({1'b0, phase_q} == (nk_cur - 4'd1));

    assign hs = rk_valid_q && rk_ready_i;
    // Completing a round key while the previous one is still unaccepted
    // would overwrite rk_q, so word production waits for the handshake.
    assign stall     = (col_cnt_q == 2'd3) && rk_valid_q && !rk_ready_i;
    assign producing = ((state_q == ST_LOAD) || (state_q == ST_EXPAND)) &&
                       !stall && !flush_i;

    always_comb begin
        case (mode_q)
            KEY_LEN_192: w_old = win_q[5];
            KEY_LEN_256: w_old = win_q[7];
            default:     w_old = win_q[3];
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        sub_o    = '0;
        temp     = win_q[0];
        use_rcon = 1'b0;
        if (state_q == ST_EXPAND) begin
            if (phase_q == 3'd0) begin
                sub_o    = rot_word(win_q[0]);
                temp     = sub_i ^ {rcon, 24'h0};
                use_rcon = 1'b1;
            end else if ((mode_q == KEY_LEN_256) && (phase_q == 3'd4)) begin
                sub_o = win_q[0];
                temp  = sub_i;
            end
        end
        new_word = (state_q == ST_LOAD) ? key_q[KEY_BITS_MAX-1 -: 32] : (w_old ^ temp);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_LOAD;
            ST_LOAD:   if (producing && phase_wrap) state_d = ST_EXPAND;
            ST_EXPAND: if (producing && (word_cnt_q == nw_last)) state_d = ST_DRAIN;
            ST_DRAIN:  if (hs) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (flush_i) state_d = ST_IDLE;
    end

    aes_rcon_gen u_rcon (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .step_i (producing && use_rcon),
        .rcon_o (rcon)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= KEY_LEN_128;
            key_q      <= '0;
            col_cnt_q  <= '0;
            word_cnt_q <= '0;
            phase_q    <= '0;
            rk_cnt_q   <= '0;
            rk_idx_q   <= '0;
            rk_q       <= '0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
            err_q      <= 1'b0;
            // NOTE: the window and collector are small register arrays, not
            // RAM, so clearing them on reset costs nothing and keeps no stale
            // key material around.
            for (int k = 0; k < 8; k++) win_q[k] <= '0;
            for (int k = 0; k < 4; k++) col_q[k] <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= 1'b0;
            if (flush_i) begin
                rk_valid_q <= 1'b0;
            end else begin
                if ((state_q == ST_IDLE) && start_i) begin
                    if (mode_ok) begin
                        mode_q     <= key_len_e'(key_len_i);
                        key_q      <= key_i;
                        col_cnt_q  <= '0;
                        word_cnt_q <= '0;
                        phase_q    <= '0;
                        rk_cnt_q   <= '0;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                if (hs) rk_valid_q <= 1'b0;
                if (producing) begin
                    for (int k = 7; k > 0; k--) win_q[k] <= win_q[k-1];
                    win_q[0]   <= new_word;
                    word_cnt_q <= word_cnt_q + 6'd1;
                    phase_q    <= phase_wrap ? 3'd0 : phase_q + 3'd1;
                    if (state_q == ST_LOAD) key_q <= key_q << 32;
                    col_q[col_cnt_q] <= new_word;
                    col_cnt_q        <= col_cnt_q + 2'd1;
                    if (col_cnt_q == 2'd3) begin
                        rk_q       <= {col_q[0], col_q[1], col_q[2], new_word};
                        rk_idx_q   <= rk_cnt_q;
                        rk_last_q  <= (rk_cnt_q == RK_IDX_W'(nr_cur));
                        rk_valid_q <= 1'b1;
                        rk_cnt_q   <= rk_cnt_q + RK_IDX_W'(1);
                    end
                end
            end
        end
    end

    assign rk_o       = rk_q;
    assign rk_valid_o = rk_valid_q;
    assign rk_idx_o   = rk_idx_q;
    assign rk_last_o  = rk_last_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DRAIN) && hs && !flush_i;
    assign err_o      = err_q;

endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 SHALL have parameter KEY_BITS_MAX, default 256, giving the largest key supported (128, 192 or 256); smaller values remove the wider modes.
REQ-002 SHALL have parameter RK_IDX_W, default 4, giving the width of the round-key index.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start_i  in  1  single-cycle request to begin expansion; sampled only in IDLE.
REQ-006 key_len_i  in  2  mode: 0=128, 1=192, 2=256, 3=illegal; sampled with start_i.
REQ-007 key_i  in  KEY_BITS_MAX  cipher key, left-justified: word w0 = bits [KEY_BITS_MAX-1 -: 32]; sampled with start_i.
REQ-008 flush_i  in  1  synchronous abort.
REQ-009 sub_o  out  32  word presented to the external shared S-box.
REQ-010 sub_i  in  32  S-box result for sub_o, combinational, same cycle.
REQ-011 rk_o  out  128  round key, w[4r] in bits [127:96].
REQ-012 rk_valid_o / rk_ready_i  out/in  1 each  valid/ready handshake for rk_o.
REQ-013 rk_idx_o  out  RK_IDX_W  round number r of rk_o.
REQ-014 rk_last_o  out  1  rk_o is the final round key (r = Nr).
REQ-015 busy_o  out  1  high in every state except IDLE.
REQ-016 done_o  out  1  one-cycle pulse on the final handshake.
REQ-017 err_o  out  1  one-cycle pulse on an illegal mode request.

Function
REQ-018 SHALL implement FIPS-197 key expansion with Nk=4/6/8, Nr=10/12/14 and Nw=4*(Nr+1)=44/52/60 words, producing at most one word per cycle.
REQ-019 FSM states SHALL be IDLE, LOAD, EXPAND and DRAIN.
- IDLE->LOAD: start_i with a legal mode.
- LOAD->EXPAND: after Nk key words.
- EXPAND->DRAIN: after word Nw-1.
- DRAIN->IDLE: on the final handshake.
REQ-020 A start_i with key_len_i=3, or a mode wider than KEY_BITS_MAX, SHALL pulse err_o next cycle and leave the block in IDLE.
REQ-021 In LOAD, key words w0..w(Nk-1) SHALL enter the 4-word collector one per cycle.
REQ-022 In EXPAND, each cycle SHALL compute w[i] = w[i-Nk] XOR temp from an Nk-deep sliding window.
- If i mod Nk = 0: temp = sub_i XOR {rcon,24'h0}, with sub_o = RotWord(w[i-1]) (rotate left by 8).
- If Nk=8 and i mod 8 = 4: temp = sub_i, with sub_o = w[i-1].
- Otherwise: temp = w[i-1], and sub_o SHALL be 0.
- Outside EXPAND, sub_o SHALL be 0.
REQ-023 rcon SHALL be set to 8'h01 at start and advance by GF(2^8) xtime after each use (8'h80 -> 8'h1B -> 8'h36).
REQ-024 On the edge where the collector receives its 4th word, rk_o, rk_idx_o and rk_last_o SHALL load, and rk_valid_o SHALL rise.
REQ-025 rk_o, rk_idx_o and rk_last_o SHALL hold stable while rk_valid_o is high and rk_ready_i is low.
REQ-026 Word production SHALL stall while completing a 4th word would overwrite an unaccepted rk_o.
REQ-027 A handshake and a new load in the same cycle SHALL be legal, giving back-to-back valid.
REQ-028 With rk_ready_i held high, start at edge t0 SHALL give round key r valid from edge t0+4(r+1); the last round key SHALL be valid at t0+Nw.
REQ-029 start_i while busy_o is high SHALL be ignored.
REQ-030 flush_i SHALL take priority over all other inputs: next edge returns to IDLE, clears rk_valid_o, and suppresses done_o.

Reset
REQ-031 rst SHALL force, asynchronously:
- state = IDLE;
- rk_o = 0, rk_idx_o = 0, rk_valid_o = 0, rk_last_o = 0, busy_o = 0, done_o = 0, err_o = 0;
- rcon = 8'h01;
- window, collector and counters = 0.
REQ-032 Reset mid-expansion SHALL discard all progress; no output pulse SHALL follow reset release.

Structure
REQ-033 aes_pkg SHALL hold the shared definitions:
- aes_word and key_128 (existing);
- new enum key_len_e;
- constants NK/NR per mode;
- an xtime function.
REQ-034 Rcon sequencing SHALL sit in one sub-module, aes_rcon_gen, with load and step controls; the S-box SHALL stay external and shared.

Verification
REQ-035 AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, ready=1:
- rk1 = a0fafe17...;
- rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with rk_last_o=1 and a done_o pulse at t0+44.
REQ-036 AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
- w6 = fe0c91f7;
- rk12 = e98ba06f448c773c8ecc720401002202.
REQ-037 AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
- w8 = 9ba35411;
- rk14 = fe4890d1e6188d0b046df344706c631e.
REQ-038 AES-128 with rk_ready_i random at 30%: identical rk sequence; rk_o stable during every stall.
REQ-039 Error and abort cases:
- key_len_i=3 -> err_o pulse, busy_o stays 0;
- flush_i at cycle 20 -> IDLE next cycle, no done_o;
- rst at cycle 20 -> all outputs 0.
